// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler sharing one 16-bit SPI DAC among NCH sample requesters.
// Optional macro DAC_SCHED_CH0_PRIO_EN: channel 0 gets fixed priority over the rest.
module dac_channel_scheduler #(
  parameter int NCH    = 4,
  parameter int CLKDIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [12*NCH-1:0] req_sample,
  output logic [NCH-1:0]    req_ready,
  output logic              spi_le,
  output logic              spi_clk,
  output logic              spi_dat,
  output logic              busy,
  output logic              frame_done
);

`ifdef DAC_SCHED_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam int DW = $clog2(2*CLKDIV);
  localparam logic [DW-1:0] HALF_END = DW'(CLKDIV-1);
  localparam logic [DW-1:0] FULL_END = DW'(2*CLKDIV-1);
  localparam logic [DW-1:0] GAP_PRE  = DW'(2*CLKDIV-2);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t          state;
  logic [DW-1:0]   div;
  logic [3:0]      bitc;
  logic [15:0]     sr;
  logic [1:0]      last_grant;
  logic [1:0]      gnt;
  logic            gnt_vld;
  logic [11:0]     gnt_sample;

  // Search starts just past the last grant; with priority, channel 0 is
  // handled up front and skipped by the rotating search.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (PRIO && req_valid[0]) begin
      gnt_vld = 1'b1;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(last_grant) + k) % NCH;
        if (!gnt_vld && !(PRIO && idx == 0) && req_valid[idx]) begin
          gnt     = 2'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++)
      req_ready[i] = (state == IDLE) && gnt_vld && (int'(gnt) == i);
  end

  assign gnt_sample = req_sample[int'(gnt)*12 +: 12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      bitc       <= '0;
      sr         <= '0;
      last_grant <= 2'(NCH-1);
      spi_le     <= 1'b1;
      spi_clk    <= 1'b0;
      spi_dat    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sr      <= {gnt, 2'b11, gnt_sample};
            spi_le  <= 1'b0;
            spi_dat <= gnt[1];
            busy    <= 1'b1;
            div     <= '0;
            bitc    <= '0;
            state   <= SETUP;
            if (!(PRIO && gnt == 2'd0)) last_grant <= gnt;
          end
        end
        SETUP: begin
          if (div == HALF_END) begin
            div     <= '0;
            spi_clk <= 1'b1;
            state   <= SHIFT;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT: begin
          if (div == FULL_END) begin
            div <= '0;
            if (bitc == 4'd15) begin
              bitc    <= '0;
              spi_le  <= 1'b1;
              spi_dat <= 1'b0;
              state   <= GAP;
            end else begin
              bitc    <= bitc + 1'b1;
              spi_clk <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
            // Falling edge: present the next bit; bit0 stays through the last low phase.
            if (div == HALF_END) begin
              spi_clk <= 1'b0;
              if (bitc != 4'd15) begin
                spi_dat <= sr[14];
                sr      <= {sr[14:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          if (div == GAP_PRE) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
          if (div == FULL_END) begin
            div   <= '0;
            state <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Randomized self-checking bench for dac_channel_scheduler: decodes the SPI pins
// and compares grants/frames against a round-robin reference model.
module tb_dac_channel_scheduler;
  localparam int NCH = 4;
  localparam int CLKDIV = 4;
`ifdef DAC_SCHED_CH0_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 0, rst = 1;
  logic [NCH-1:0] req_valid = '0;
  logic [12*NCH-1:0] req_sample = '0;
  logic [NCH-1:0] req_ready;
  logic spi_le, spi_clk, spi_dat, busy, frame_done;

  dac_channel_scheduler #(.NCH(NCH), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sample(req_sample),
    .req_ready(req_ready), .spi_le(spi_le), .spi_clk(spi_clk), .spi_dat(spi_dat),
    .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Pin monitor: grants, frame_done times, decoded words, spi_le low widths.
  int gq[$], gcyc[$], dq[$], lq[$], bq[$];
  logic [15:0] wq[$];
  logic [15:0] word = 0;
  int lelen = 0, nbits = 0;
  logic pclk = 0, ple = 1;
  always @(negedge clk) begin
    if (req_ready != 0) begin
      gq.push_back($onehot(req_ready) ? $clog2(int'(req_ready)) : 99);
      gcyc.push_back(cyc);
    end
    if (frame_done === 1'b1) dq.push_back(cyc);
    if (spi_le === 1'b0) begin
      lelen++;
      if (spi_clk === 1'b1 && pclk === 1'b0) begin word = {word[14:0], spi_dat}; nbits++; end
    end
    if (spi_le === 1'b1 && ple === 1'b0) begin
      wq.push_back(word); lq.push_back(lelen); bq.push_back(nbits);
      word = 0; lelen = 0; nbits = 0;
    end
    pclk = spi_clk; ple = spi_le;
  end

  // Reference model state
  int model_last;
  logic [11:0] samp [NCH];

  function automatic int exp_grant(input int last, input logic [NCH-1:0] v);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= NCH; k++) begin
      int c = (last + k) % NCH;
      if (v[c] && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_word(input int ch);
    logic [1:0] c2 = 2'(ch);
    return {c2, 2'b11, samp[ch]};
  endfunction

  task automatic clear_q();
    gq.delete(); gcyc.delete(); dq.delete(); wq.delete(); lq.delete(); bq.delete();
  endtask

  task automatic set_samples_random();
    for (int i = 0; i < NCH; i++) begin
      samp[i] = 12'($urandom);
      req_sample[12*i +: 12] = samp[i];
    end
  endtask

  task automatic set_sample(input int ch, input logic [11:0] v);
    samp[ch] = v;
    req_sample[12*ch +: 12] = v;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int t = 0;
    while (gq.size() < n && t < budget) begin @(negedge clk); t++; end
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (dq.size() < n && t < budget) begin @(negedge clk); t++; end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    model_last = NCH - 1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_reset();
    bit bad = 0;
    req_valid = '0; rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spi_le, spi_clk, spi_dat, busy, frame_done, req_ready} !== {5'b10000, 4'b0000})
      $display("FAIL reset_outputs got le=%b clk=%b dat=%b busy=%b done=%b rdy=%b exp 1 0 0 0 0 0000",
               spi_le, spi_clk, spi_dat, busy, frame_done, req_ready);
    else n_pass++;
    rst = 0; model_last = NCH - 1;
    clear_q();
    repeat (200) begin
      @(negedge clk);
      if (spi_le !== 1'b1 || spi_clk !== 1'b0 || busy !== 1'b0 || req_ready !== '0) bad = 1;
    end
    n_checks++;
    if (bad || gq.size() != 0 || dq.size() != 0)
      $display("FAIL idle_quiet got bad=%0d grants=%0d dones=%0d exp 0 0 0", bad, gq.size(), dq.size());
    else n_pass++;
  endtask

  task automatic test_single();
    int mid_busy;
    clear_q();
    set_sample(0, 12'hA5C);
    req_valid = 4'b0001;
    wait_grants(1, 400);
    @(posedge clk); #1 req_valid = '0;
    repeat (60) @(negedge clk);
    mid_busy = busy;
    wait_done(1, 400);
    @(negedge clk);
    n_checks++;
    if (gq.size() != 1 || gq[0] != 0) $display("FAIL single_grant got n=%0d ch=%0d exp 1 0", gq.size(), gq.size() ? gq[0] : -1);
    else n_pass++;
    n_checks++;
    if (wq.size() != 1 || wq[0] !== 16'h3A5C) $display("FAIL single_word got %h exp 3a5c", wq.size() ? wq[0] : 16'hxxxx);
    else n_pass++;
    n_checks++;
    if (lq.size() != 1 || lq[0] != 33*CLKDIV) $display("FAIL single_le_len got %0d exp %0d", lq.size() ? lq[0] : -1, 33*CLKDIV);
    else n_pass++;
    n_checks++;
    if (dq.size() != 1 || gcyc.size() != 1 || dq[0] - gcyc[0] != 35*CLKDIV) $display("FAIL single_done_lat got %0d exp %0d",
        (dq.size() && gcyc.size()) ? dq[0] - gcyc[0] : -1, 35*CLKDIV);
    else n_pass++;
    n_checks++;
    if (mid_busy !== 1) $display("FAIL single_busy got %0d exp 1", mid_busy);
    else n_pass++;
    if (gq.size() == 1) model_last = gq[0];
  endtask

  task automatic test_round_robin();
    int ec, bad_g = 0, bad_w = 0, bad_t = 0;
    do_reset();
    set_sample(0, 12'h100); set_sample(1, 12'h201); set_sample(2, 12'h302); set_sample(3, 12'h403);
    req_valid = '1;
    wait_grants(5, 1000);
    @(posedge clk); #1 req_valid = '0;
    wait_done(5, 400);
    @(negedge clk);
    n_checks++;
    if (gq.size() != 5 || wq.size() != 5) $display("FAIL rr_count got grants=%0d words=%0d exp 5 5", gq.size(), wq.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        ec = exp_grant(model_last, 4'b1111);
        if (gq[i] != ec) bad_g++;
        if (wq[i] !== exp_word(ec)) bad_w++;
        if (i > 0 && gcyc[i] - gcyc[i-1] != 35*CLKDIV + 1) bad_t++;
        if (!(PRIO && ec == 0)) model_last = ec;
      end
      n_checks++;
      if (bad_g) $display("FAIL rr_order got %0d,%0d,%0d,%0d,%0d bad=%0d", gq[0], gq[1], gq[2], gq[3], gq[4], bad_g);
      else n_pass++;
      n_checks++;
      if (bad_w) $display("FAIL rr_words got %h %h %h %h bad=%0d", wq[0], wq[1], wq[2], wq[3], bad_w);
      else n_pass++;
      n_checks++;
      if (bad_t) $display("FAIL rr_period got %0d exp %0d", gcyc[1] - gcyc[0], 35*CLKDIV + 1);
      else n_pass++;
    end
  endtask

  task automatic test_sparse(input logic [NCH-1:0] mask, input int n, input string name);
    int ec, bad = 0;
    clear_q();
    set_samples_random();
    req_valid = mask;
    wait_grants(n, 200*n);
    @(posedge clk); #1 req_valid = '0;
    wait_done(n, 400);
    @(negedge clk);
    n_checks++;
    if (gq.size() != n || wq.size() != n) $display("FAIL %s_count got %0d/%0d exp %0d", name, gq.size(), wq.size(), n);
    else begin
      for (int i = 0; i < n; i++) begin
        ec = exp_grant(model_last, mask);
        if (gq[i] != ec || wq[i] !== exp_word(ec)) begin
          bad++;
          $display("FAIL %s_frame%0d got ch=%0d word=%h exp ch=%0d word=%h", name, i, gq[i], wq[i], ec, exp_word(ec));
        end
        if (!(PRIO && ec == 0)) model_last = ec;
      end
      if (bad == 0) n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int t = 0;
    clear_q();
    set_samples_random();
    req_valid = 4'b0010;
    wait_grants(1, 400);
    @(posedge clk); #1 req_valid = '0;
    while (nbits < 7 && t < 400) begin @(negedge clk); t++; end
    rst = 1;
    @(negedge clk);
    n_checks++;
    if (spi_le !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_abort got le=%b done=%b busy=%b bits=%0d exp 1 0 0", spi_le, frame_done, busy, nbits);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 0; model_last = NCH - 1;
    repeat (150) @(negedge clk);
    n_checks++;
    if (dq.size() != 0) $display("FAIL midrst_no_done got %0d exp 0", dq.size());
    else n_pass++;
    clear_q();
    req_valid = 4'b0100;
    wait_grants(1, 400);
    @(posedge clk); #1 req_valid = '0;
    wait_done(1, 400);
    @(negedge clk);
    n_checks++;
    if (gq.size() != 1 || gq[0] != 2 || wq.size() != 1 || wq[0] !== exp_word(2) || bq[0] != 16 || lq[0] != 33*CLKDIV)
      $display("FAIL midrst_recover got ch=%0d word=%h bits=%0d exp ch=2 word=%h bits=16",
               gq.size() ? gq[0] : -1, wq.size() ? wq[0] : 16'hxxxx, bq.size() ? bq[0] : -1, exp_word(2));
    else n_pass++;
    model_last = PRIO ? model_last : 2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_sparse(4'b1010, 3, "sparse13");
    for (int r = 0; r < 4; r++) test_sparse(4'($urandom_range(1, 15)), 3, "random");
    test_reset_mid_frame();
`ifdef DAC_SCHED_CH0_PRIO_EN
    do_reset();
    test_sparse(4'b1111, 3, "prio_all");
    test_sparse(4'b1110, 4, "prio_no0");
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got running exp finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end
endmodule
